eth_tx_framer: RTL and testbench
================================

Name: eth_tx_framer

Overview:
- Parametrised transmit framer: converts a byte stream into MII/RMII-style symbols on TXEN/TXD.
- Inserts preamble and SFD, computes and appends the IEEE 802.3 FCS, and enforces the inter-frame gap.
- Sits between the MAC payload source and the PHY pins (ETH_TXEN/ETH_TXD) in eth_top.
- Also serves as a synthesizable frame source for loopback on the RX path.

Parameters:
- DATA_W, 2, symbol width in bits; legal values 2 (RMII), 4 (MII), 8 (byte-wide); any other value is an elaboration error.
- PREAMBLE_BYTES, 7, number of 0x55 bytes before the SFD (0xD5).
- IFG_BYTES, 12, idle gap after FCS, in byte times.
- CNT_W, 16, width of the frame counter.

Ports:
- CLK  in  1  system clock; one TXD symbol per cycle.
- RST_N  in  1  synchronous active-low reset.
- S_DATA  in  8  payload byte.
- S_VALID  in  1  S_DATA/S_LAST valid.
- S_LAST  in  1  marks final payload byte.
- S_READY  out  1  byte accepted on cycles where S_VALID&&S_READY.
- TXEN  out  1  transmit enable.
- TXD  out  DATA_W  symbol, LSB-first within byte.
- BUSY  out  1  high in any state other than IDLE.
- UNDERRUN  out  1  one-cycle pulse on aborted frame.
- FRAME_CNT  out  CNT_W  count of completed (non-aborted) frames; wraps.

Behaviour:
- Reset: all outputs 0; state IDLE; CRC register = 0xFFFFFFFF. Reset mid-frame drops TXEN on the next edge with no FCS; the frame is not counted.
- SPB = 8/DATA_W cycles per byte. Bytes are shifted LSB-first: the low DATA_W bits go first.
- States: IDLE → PRE → SFD → DATA → [PAD] → FCS → IFG → IDLE.
- IDLE: TXEN=0, S_READY=0. S_VALID=1 at cycle t moves to PRE; TXEN=1 from t+1.
- PRE: PREAMBLE_BYTES×SPB cycles of 0x55 symbols. SFD: SPB cycles of 0xD5.
- S_READY is high only on the final symbol cycle of SFD and of each DATA byte, and only while S_LAST has not yet been accepted. The accepted byte appears on TXD from the next cycle.
- DATA: accepted bytes are fed into CRC-32 (reflected poly 0xEDB88320, init 0xFFFFFFFF) at acceptance.
- Underrun: S_VALID=0 at a ready cycle →
  - TXEN=0 next cycle;
  - UNDERRUN pulses for 1 cycle;
  - go to IFG; no FCS; FRAME_CNT unchanged.
- After S_LAST is accepted and that byte is transmitted: go to PAD (if enabled and required) or FCS.
- FCS: 4 bytes of ~CRC, low byte first, each LSB-first; SPB×4 cycles.
- On the last FCS cycle: FRAME_CNT increments (wraps at 2^CNT_W).
- IFG: TXEN=0, TXD=0 for IFG_BYTES×SPB cycles; BUSY stays 1. Then IDLE; a new frame may start on the first IDLE cycle.
- TXD is 0 whenever TXEN=0.
- Payload length counter saturates at 64; it is used only for padding.
- A zero-length frame is impossible: the first accepted byte exists or an underrun occurs.
- Frame length on the wire = (PREAMBLE_BYTES+1+N+4)×SPB cycles of TXEN, where N = payload bytes (after pad).

Optional Feature:
- Macro ETH_TX_PAD_EN.
- Defined: if the payload is shorter than 60 bytes, the PAD state emits 0x00 bytes, included in the CRC, until 60 bytes are sent; then FCS.
- Undefined: the PAD state and length counter are omitted; frames go out at the supplied length.

Test Plan:
- DATA_W=2, pad off: send ASCII "123456789" (0x31..0x39) back-to-back →
  - 28 cycles of TXD=2'b01, then SFD dibits 01,01,01,11;
  - payload, then FCS bytes 0x26,0x39,0xF4,0xCB;
  - TXEN high for (8+9+4)×4=84 cycles, then 48 idle cycles;
  - FRAME_CNT=1.
- DATA_W=4, ETH_TX_PAD_EN, 9-byte payload → TXEN high (8+60+4)×2=144 cycles; bytes 10..60 are 0x00; FCS matches the reference CRC over 60 bytes.
- DATA_W=2: drop S_VALID at the 3rd byte's ready cycle → TXEN falls next cycle, UNDERRUN=1 for one cycle, FRAME_CNT unchanged, BUSY low after 48 IFG cycles.
- Two frames with S_VALID held high → second TXEN rise exactly IFG_BYTES×SPB+1 cycles after the first TXEN fall.
- Assert RST_N=0 for 1 cycle mid-payload → TXEN, S_READY, BUSY = 0 next cycle; the next frame is correct with CRC re-initialised.
- CNT_W=4, send 17 frames → FRAME_CNT reads 1 (wrap).

Source files
------------

// File: rtl/eth_tx_framer_if.sv
// eth_tx_framer_if: payload byte stream from the MAC source into the framer.
interface eth_tx_framer_if;
    logic [7:0] S_DATA;
    logic       S_VALID;
    logic       S_LAST;
    logic       S_READY;
    modport master (output S_DATA, S_VALID, S_LAST, input S_READY);
    modport slave (input S_DATA, S_VALID, S_LAST, output S_READY);
endinterface

// File: rtl/eth_tx_framer.sv
// eth_tx_framer: byte stream to MII/RMII symbols with preamble, SFD, FCS and inter-frame gap.
// Define ETH_TX_PAD_EN to zero-pad payloads shorter than 60 bytes before the FCS.
module eth_tx_framer #(
    parameter int DATA_W         = 2,
    parameter int PREAMBLE_BYTES = 7,
    parameter int IFG_BYTES      = 12,
    parameter int CNT_W          = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    eth_tx_framer_if.slave    s,
    output logic              TXEN,
    output logic [DATA_W-1:0] TXD,
    output logic              BUSY,
    output logic              UNDERRUN,
    output logic [CNT_W-1:0]  FRAME_CNT
);
    localparam int SPB = 8 / DATA_W;
    localparam logic [2:0]  SYM_END = 3'(SPB - 1);
    localparam logic [15:0] PRE_END = 16'(PREAMBLE_BYTES * SPB - 1);
    localparam logic [15:0] FCS_END = 16'(4 * SPB - 1);
    localparam logic [15:0] IFG_END = 16'(IFG_BYTES * SPB - 1);

    if (!(DATA_W == 2 || DATA_W == 4 || DATA_W == 8)) begin : g_bad_width
        $error("eth_tx_framer: DATA_W must be 2, 4 or 8");
    end

    typedef enum logic [2:0] {
        IDLE, PRE, SFD, DATA,
`ifdef ETH_TX_PAD_EN
        PAD,
`endif
        FCS, IFG
    } state_t;

    state_t state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0] sh_q, sh_d;
    logic [31:0] crc_q, crc_d;
    logic last_q, last_d;
    logic und_q, und_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic last_sym, rdy, fcs_ld;
`ifdef ETH_TX_PAD_EN
    logic [6:0] len_q, len_d;
    logic pad_ld;
`endif

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
        return r;
    endfunction

    // cnt_q runs continuously through SFD/DATA/PAD, so its low bits give the symbol slot.
    assign last_sym = (cnt_q[2:0] & SYM_END) == SYM_END;
    assign rdy = (state_q == SFD || state_q == DATA) && last_sym && !last_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q <= '0;
            sh_q <= '0;
            crc_q <= '1;
            last_q <= 1'b0;
            und_q <= 1'b0;
            fcnt_q <= '0;
`ifdef ETH_TX_PAD_EN
            len_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            sh_q <= sh_d;
            crc_q <= crc_d;
            last_q <= last_d;
            und_q <= und_d;
            fcnt_q <= fcnt_d;
`ifdef ETH_TX_PAD_EN
            len_q <= len_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q + 16'd1;
        sh_d = sh_q >> DATA_W;
        crc_d = crc_q;
        last_d = last_q;
        und_d = 1'b0;
        fcnt_d = fcnt_q;
        fcs_ld = 1'b0;
`ifdef ETH_TX_PAD_EN
        pad_ld = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (s.S_VALID) begin
                    state_d = PRE;
                    sh_d = 8'h55;
                    crc_d = '1;
                    last_d = 1'b0;
                end
            end
            PRE: begin
                if (cnt_q == PRE_END) begin
                    state_d = SFD;
                    cnt_d = '0;
                    sh_d = 8'hD5;
                end else if (last_sym) begin
                    sh_d = 8'h55;
                end
            end
            SFD, DATA: begin
                if (rdy && s.S_VALID) begin
                    state_d = DATA;
                    sh_d = s.S_DATA;
                    crc_d = crc_byte(crc_q, s.S_DATA);
                    last_d = s.S_LAST;
                end else if (rdy) begin
                    state_d = IFG;
                    cnt_d = '0;
                    und_d = 1'b1;
                end else if (last_sym) begin
`ifdef ETH_TX_PAD_EN
                    if (len_q < 7'd60) pad_ld = 1'b1; else
`endif
                    fcs_ld = 1'b1;
                end
            end
`ifdef ETH_TX_PAD_EN
            PAD: begin
                if (last_sym) begin
                    if (len_q < 7'd60) pad_ld = 1'b1; else fcs_ld = 1'b1;
                end
            end
`endif
            FCS: begin
                if (cnt_q == FCS_END) begin
                    state_d = IFG;
                    cnt_d = '0;
                    fcnt_d = fcnt_q + CNT_W'(1);
                end else if (last_sym) begin
                    sh_d = ~crc_q[7:0];
                    crc_d = {8'h00, crc_q[31:8]};
                end
            end
            IFG: begin
                if (cnt_q == IFG_END) begin
                    state_d = IDLE;
                    cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef ETH_TX_PAD_EN
        if (pad_ld) begin
            state_d = PAD;
            sh_d = 8'h00;
            crc_d = crc_byte(crc_q, 8'h00);
        end
        len_d = state_q == IDLE ? 7'd0 :
                (((rdy && s.S_VALID) || pad_ld) && len_q != 7'd64) ? len_q + 7'd1 : len_q;
`endif
        if (fcs_ld) begin
            state_d = FCS;
            cnt_d = '0;
            sh_d = ~crc_q[7:0];
            crc_d = {8'h00, crc_q[31:8]};
        end
    end

    always_comb begin
        TXEN = !(state_q inside {IDLE, IFG});
        TXD = TXEN ? sh_q[DATA_W-1:0] : '0;
        BUSY = state_q != IDLE;
        UNDERRUN = und_q;
        FRAME_CNT = fcnt_q;
        s.S_READY = rdy;
    end
endmodule

// File: tb/tb_eth_tx_framer.sv
// tb_eth_tx_framer: directed frames on RMII, MII and byte-wide framers with hand-computed expectations.
module tb_eth_tx_framer;
`ifdef ETH_TX_PAD_EN
    localparam int PADN = 60;
`else
    localparam int PADN = 0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] sdata = 8'h00;
    logic svalid = 1'b0;
    logic slast = 1'b0;
    int sel = 0;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int txcnt, rise, fall, bdone, und_cnt;
    logic [7:0] wire_q [$];
    logic [7:0] pay [0:63];

    eth_tx_framer_if i2 ();
    eth_tx_framer_if i4 ();
    eth_tx_framer_if i8 ();
    assign i2.S_DATA = sdata;
    assign i2.S_VALID = svalid && sel == 0;
    assign i2.S_LAST = slast;
    assign i4.S_DATA = sdata;
    assign i4.S_VALID = svalid && sel == 1;
    assign i4.S_LAST = slast;
    assign i8.S_DATA = sdata;
    assign i8.S_VALID = svalid && sel == 2;
    assign i8.S_LAST = slast;

    logic txen2, bsy2, und2, txen4, bsy4, und4, txen8, bsy8, und8;
    logic [1:0] txd2;
    logic [3:0] txd4;
    logic [7:0] txd8;
    logic [15:0] fc2, fc4;
    logic [3:0] fc8;

    eth_tx_framer #(.DATA_W(2)) u2 (.CLK(clk), .RST_N(rst_n), .s(i2), .TXEN(txen2), .TXD(txd2), .BUSY(bsy2), .UNDERRUN(und2), .FRAME_CNT(fc2));
    eth_tx_framer #(.DATA_W(4)) u4 (.CLK(clk), .RST_N(rst_n), .s(i4), .TXEN(txen4), .TXD(txd4), .BUSY(bsy4), .UNDERRUN(und4), .FRAME_CNT(fc4));
    eth_tx_framer #(.DATA_W(8), .CNT_W(4)) u8 (.CLK(clk), .RST_N(rst_n), .s(i8), .TXEN(txen8), .TXD(txd8), .BUSY(bsy8), .UNDERRUN(und8), .FRAME_CNT(fc8));

    always #5 clk = ~clk;

    logic txen_m, bsy_m, und_m, rdy_m;
    logic [7:0] txd_m;
    always_comb begin
        txen_m = sel == 0 ? txen2 : sel == 1 ? txen4 : txen8;
        bsy_m = sel == 0 ? bsy2 : sel == 1 ? bsy4 : bsy8;
        und_m = sel == 0 ? und2 : sel == 1 ? und4 : und8;
        rdy_m = sel == 0 ? i2.S_READY : sel == 1 ? i4.S_READY : i8.S_READY;
        txd_m = sel == 0 ? {6'b0, txd2} : sel == 1 ? {4'b0, txd4} : txd8;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int wl(input int n);
        return n < PADN ? PADN : n;
    endfunction

    function automatic logic [31:0] fcs_of(input int first, input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++)
            for (int b = 0; b < 8; b++)
                c = (c[0] ^ wire_q[first+i][b]) ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
        return ~c;
    endfunction

    function automatic logic [31:0] fcs_got();
        int l;
        l = wire_q.size();
        return {wire_q[l-1], wire_q[l-2], wire_q[l-3], wire_q[l-4]};
    endfunction

    // Called at a negedge with the selected framer idle; returns at the negedge of its first idle cycle.
    task automatic run_frame(input int n, input int drop, input int rst_at);
        int k, pos, w, t;
        logic [7:0] acc;
        logic seen, ab;
        k = 0; pos = 0; acc = 8'h00; seen = 1'b0; ab = 1'b0;
        w = sel == 0 ? 2 : sel == 1 ? 4 : 8;
        wire_q.delete();
        txcnt = 0; rise = -1; fall = -1; und_cnt = 0; bdone = -1;
        for (t = 0; t < 4000; t++) begin
            if (bsy_m) seen = 1'b1;
            if (seen && !bsy_m) break;
            if (txen_m) begin
                if (rise < 0) rise = cyc;
                txcnt++;
                acc = acc | 8'(txd_m << pos);
                pos += w;
                if (pos == 8) begin
                    wire_q.push_back(acc);
                    acc = 8'h00;
                    pos = 0;
                end
            end else if (rise >= 0 && fall < 0) begin
                fall = cyc;
            end
            if (und_m) und_cnt++;
            svalid = !ab && k < n && k != drop;
            sdata = pay[k];
            slast = k == n - 1;
            if (rdy_m && svalid) k++;
            if (rst_at > 0 && txcnt == rst_at && !ab) begin
                rst_n = 1'b0;
                ab = 1'b1;
            end
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                check("rst_txen", 32'(txen_m), 32'd0);
                check("rst_ready", 32'(rdy_m), 32'd0);
                check("rst_busy", 32'(bsy_m), 32'd0);
                rst_n = 1'b1;
            end
        end
        bdone = cyc;
        check("frame_done", 32'(seen && !bsy_m), 32'd1);
        svalid = 1'b0;
    endtask

    initial begin
        int f1, nz;
        for (int i = 0; i < 64; i++) pay[i] = i < 9 ? 8'(8'h31 + i) : 8'h00;
        repeat (3) @(negedge clk);
        check("reset_txen", 32'(txen2), 32'd0);
        check("reset_txd", 32'(txd2), 32'd0);
        check("reset_busy", 32'(bsy2), 32'd0);
        check("reset_underrun", 32'(und2), 32'd0);
        check("reset_ready", 32'(i2.S_READY), 32'd0);
        check("reset_cnt", 32'(fc2), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        // "123456789" on RMII
        run_frame(9, -1, 0);
        check("t1_txen_cycles", txcnt, 32'((8 + wl(9) + 4) * 4));
        check("t1_preamble", {wire_q[0], wire_q[1], wire_q[2], wire_q[3]}, 32'h55555555);
        check("t1_pre_sfd", {wire_q[4], wire_q[5], wire_q[6], wire_q[7]}, 32'h555555D5);
        check("t1_payload", {wire_q[8], wire_q[9], wire_q[10], wire_q[16]}, 32'h31323339);
        check("t1_fcs", fcs_got(), PADN == 0 ? 32'hCBF43926 : fcs_of(8, 60));
        check("t1_ifg", bdone - fall, 32'd48);
        check("t1_cnt", 32'(fc2), 32'd1);
        f1 = fall;
        // back-to-back second frame starts on the first idle cycle
        run_frame(9, -1, 0);
        check("t2_gap", rise - f1, 32'd49);
        check("t2_fcs", fcs_got(), fcs_of(8, wl(9)));
        check("t2_cnt", 32'(fc2), 32'd2);
        // underrun at the third byte
        run_frame(9, 2, 0);
        check("t3_txen_cycles", txcnt, 32'd40);
        check("t3_underrun_pulses", und_cnt, 32'd1);
        check("t3_ifg", bdone - fall, 32'd48);
        check("t3_cnt", 32'(fc2), 32'd2);
        // reset mid-payload, then a clean frame
        run_frame(9, -1, 50);
        check("t4_cnt_cleared", 32'(fc2), 32'd0);
        run_frame(9, -1, 0);
        check("t4_txen_cycles", txcnt, 32'((8 + wl(9) + 4) * 4));
        check("t4_fcs", fcs_got(), PADN == 0 ? 32'hCBF43926 : fcs_of(8, 60));
        check("t4_cnt", 32'(fc2), 32'd1);
        // MII width
        sel = 1;
        run_frame(9, -1, 0);
        check("t5_txen_cycles", txcnt, 32'((8 + wl(9) + 4) * 2));
        check("t5_payload", {wire_q[8], wire_q[9], wire_q[15], wire_q[16]}, 32'h31323839);
        check("t5_fcs", fcs_got(), fcs_of(8, wl(9)));
        check("t5_cnt", 32'(fc4), 32'd1);
`ifdef ETH_TX_PAD_EN
        nz = 0;
        for (int i = 17; i < 68; i++) if (wire_q[i] != 8'h00) nz++;
        check("t5_pad_zero", nz, 32'd0);
`endif
        // byte-wide framer with a 4-bit counter wraps after 16 frames
        sel = 2;
        for (int i = 0; i < 16; i++) run_frame(1, -1, 0);
        check("t6_cnt_wrapped", 32'(fc8), 32'd0);
        run_frame(1, -1, 0);
        check("t6_cnt", 32'(fc8), 32'd1);
        check("t6_txen_cycles", txcnt, 32'(8 + wl(1) + 4));
        check("t6_fcs", fcs_got(), fcs_of(8, wl(1)));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
